// File: rtl/powlib_dpram_wrarb_pkg.sv
// Shared types and helpers for the powlib dpram write-port arbiter.
// Holds the FSM state encoding and the ceil-log2 width helper.
package powlib_dpram_wrarb_pkg;

  typedef enum logic {
    WRARB_IDLE = 1'b0,
    WRARB_LOCK = 1'b1
  } wrarb_state_t;

  // Width needed to index 'value' entries, never less than one bit.
  function automatic int powlib_clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/powlib_dpram_wrarb_rrpick.sv
// Combinational rotate-priority picker: first set bit of req starting at ptr,
// wrapping modulo N. Returns a one-hot grant, its id and whether anything was picked.
module powlib_rrpick #(
  parameter int N  = 4,
  parameter int WN = 2
) (
  input  logic [N-1:0]  req,
  input  logic [WN-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [WN-1:0] id,
  output logic          any
);

  int pos;

  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!any && req[pos[WN-1:0]]) begin
        any                = 1'b1;
        gnt[pos[WN-1:0]]   = 1'b1;
        id                 = pos[WN-1:0];
      end
    end
  end

endmodule

// File: rtl/powlib_dpram_wrarb.sv
// Round-robin arbiter sharing one powlib_dpram write port among N requesters.
// Optional grant locking is built when POWLIB_DPRAM_WRARB_LOCK_EN is defined.
module powlib_dpram_wrarb
  import powlib_dpram_wrarb_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int WIDX = powlib_clogb2(D),
  parameter int WN   = powlib_clogb2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_vld,
  output logic [N-1:0]    req_rdy,
  input  logic [N*WIDX-1:0] req_idx,
  input  logic [N*W-1:0]  req_data,
  input  logic [N-1:0]    req_lock,
  output logic [WIDX-1:0] wridx,
  output logic [W-1:0]    wrdata,
  output logic            wrvld,
  output logic [WN-1:0]   gntid
);

  logic [1:0]    rst_sync;
  logic          rst_int;
  logic [WN-1:0] ptr;
  logic [WN-1:0] ptr_next;
  logic [N-1:0]  elig;
  logic [N-1:0]  pick_gnt;
  logic [WN-1:0] pick_id;
  logic          pick_any;
  logic          accept;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int = rst_sync[1];

`ifdef POWLIB_DPRAM_WRARB_LOCK_EN
  wrarb_state_t  state;
  logic [WN-1:0] owner;

  always_comb begin
    elig = req_vld;
    if (state == WRARB_LOCK) elig = req_vld & (N'(1) << owner);
  end

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      state <= WRARB_IDLE;
      owner <= '0;
    end else if (accept) begin
      case (state)
        WRARB_IDLE: begin
          if (req_lock[pick_id]) begin
            state <= WRARB_LOCK;
            owner <= pick_id;
          end
        end
        WRARB_LOCK: begin
          if (!req_lock[pick_id]) state <= WRARB_IDLE;
        end
        default: state <= WRARB_IDLE;
      endcase
    end
  end
`else
  logic unused_lock;

  assign elig        = req_vld;
  assign unused_lock = ^req_lock;
`endif

  powlib_rrpick #(
    .N  (N),
    .WN (WN)
  ) u_pick (
    .req (elig),
    .ptr (ptr),
    .gnt (pick_gnt),
    .id  (pick_id),
    .any (pick_any)
  );

  // Nothing is accepted while the synchronised reset is still held.
  assign req_rdy  = rst_int ? pick_gnt : '0;
  assign accept   = rst_int & pick_any;
  assign ptr_next = (pick_id == WN'(N - 1)) ? '0 : pick_id + 1'b1;

  // In LOCK only the owner wins, so ptr already equals owner+1 and stays put.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      wrvld  <= 1'b0;
      wridx  <= '0;
      wrdata <= '0;
      gntid  <= '0;
      ptr    <= '0;
    end else begin
      wrvld <= accept;
      if (accept) begin
        wridx  <= req_idx[WIDX*pick_id +: WIDX];
        wrdata <= req_data[W*pick_id +: W];
        gntid  <= pick_id;
        ptr    <= ptr_next;
      end
    end
  end

endmodule
